// File: rtl/burst_tx.sv
`default_nettype none
// ============================================================================
//  Module   : burst_tx
//  Purpose  : Burst transmitter (initiator side of the RAM burst buffer).
//             Gathers BURST_LEN words from a valid/ready word source into a
//             local register buffer, waits for burst permission, then emits
//             the whole burst with m_valid_o high for BURST_LEN contiguous
//             cycles. A fixed idle gap follows every burst.
//  Ports    : clk           clock, all logic on rising edge
//             rst           synchronous reset, active-low
//             s_data_i      source word
//             s_valid_i     source word valid
//             s_ready_o     word accepted this cycle (combinational)
//             m_data_o      burst word to the buffer (registered)
//             m_valid_o     burst word valid (registered)
//             m_ready_i     buffer can take one whole burst
//             burst_done_o  one-cycle pulse after the last burst word
//  Revision : 1.0  initial release
// ============================================================================
module burst_tx #(
    parameter int DATABIT   = 32,
    parameter int BURST_LEN = 4,
    parameter int IDX_BIT   = 2,
    parameter int GAP_CYC   = 2,
    parameter int GAP_BIT   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATABIT-1:0] s_data_i,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    output logic [DATABIT-1:0] m_data_o,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic               burst_done_o
);

    localparam logic [1:0] c_ST_FILL = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_SEND = 2'd2;
    localparam logic [1:0] c_ST_GAP  = 2'd3;

    localparam logic [IDX_BIT-1:0] c_IDX_LAST  = IDX_BIT'(BURST_LEN - 1);
    // Index of the second burst word. With a single-word burst there is no
    // second word, so SEND starts already wrapped to 0 and ends at once.
    localparam logic [IDX_BIT-1:0] c_IDX_SEND1 = (BURST_LEN == 1) ? '0 : IDX_BIT'(1);
    localparam logic [GAP_BIT-1:0] c_GAP_LOAD  = GAP_BIT'(GAP_CYC - 1);

    logic [1:0]         state_q, state_d;
    logic [IDX_BIT-1:0] idx_q, idx_d;
    logic [GAP_BIT-1:0] gap_q, gap_d;
    logic               m_valid_q, m_valid_d;
    logic [DATABIT-1:0] m_data_q, m_data_d;
    logic               done_q, done_d;
    logic [DATABIT-1:0] mem_q [BURST_LEN];

    logic               w_accept;
    logic [IDX_BIT-1:0] w_idx_inc;

    assign s_ready_o    = rst & (state_q == c_ST_FILL);
    assign w_accept     = s_valid_i & s_ready_o;
    assign m_data_o     = m_data_q;
    assign m_valid_o    = m_valid_q;
    assign burst_done_o = done_q;

    // Index increment with wrap at the last word, so idx stays within the buffer.
    assign w_idx_inc = (idx_q == c_IDX_LAST) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        done_d    = 1'b0;
        case (state_q)
            c_ST_FILL: begin
                if (w_accept) begin
                    idx_d = w_idx_inc;
                    if (idx_q == c_IDX_LAST) begin
                        state_d = c_ST_WAIT;
                    end
                end
            end
            c_ST_WAIT: begin
                if (m_ready_i) begin
                    m_valid_d = 1'b1;
                    m_data_d  = mem_q[0];
                    idx_d     = c_IDX_SEND1;
                    state_d   = c_ST_SEND;
                end
            end
            c_ST_SEND: begin
                // idx wraps to 0 once the last word has been driven; that
                // wrap is the end-of-burst marker.
                if (idx_q == '0) begin
                    m_valid_d = 1'b0;
                    m_data_d  = '0;
                    done_d    = 1'b1;
                    idx_d     = '0;
                    gap_d     = c_GAP_LOAD;
                    state_d   = c_ST_GAP;
                end else begin
                    m_data_d = mem_q[idx_q];
                    idx_d    = w_idx_inc;
                end
            end
            c_ST_GAP: begin
                m_valid_d = 1'b0;
                if (gap_q == '0) begin
                    state_d = c_ST_FILL;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = c_ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= c_ST_FILL;
            idx_q     <= '0;
            gap_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            done_q    <= done_d;
        end
    end

    // Buffer contents need no reset; writes are already gated by s_ready_o.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            mem_q[idx_q] <= s_data_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_burst_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_burst_tx
//  Purpose  : Directed self-checking bench for burst_tx (BURST_LEN=4,
//             GAP_CYC=2). Inputs change and outputs are sampled on the
//             falling clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_burst_tx;

    localparam int DATABIT = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [DATABIT-1:0] s_data_i = '0;
    logic               s_valid_i = 1'b0;
    logic               s_ready_o;
    logic [DATABIT-1:0] m_data_o;
    logic               m_valid_o;
    logic               m_ready_i = 1'b0;
    logic               burst_done_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Output monitor state
    logic [DATABIT-1:0] words[$];
    int                 runs[$];
    int                 lows[$];
    int                 cur_run  = 0;
    int                 low_run  = 0;
    int                 done_cnt = 0;
    logic               prev_mv  = 1'b0;

    always #5 clk = ~clk;

    burst_tx #(
        .DATABIT  (32),
        .BURST_LEN(4),
        .IDX_BIT  (2),
        .GAP_CYC  (2),
        .GAP_BIT  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_data_i    (s_data_i),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .burst_done_o(burst_done_o)
    );

    always @(negedge clk) begin
        if (m_valid_o === 1'b1) begin
            if (!prev_mv) begin
                lows.push_back(low_run);
                low_run = 0;
            end
            words.push_back(m_data_o);
            cur_run++;
            prev_mv = 1'b1;
        end else begin
            if (prev_mv) runs.push_back(cur_run);
            cur_run = 0;
            low_run++;
            prev_mv = 1'b0;
        end
        if (burst_done_o === 1'b1) done_cnt++;
    end

    task automatic clear_mon();
        words.delete();
        runs.delete();
        lows.delete();
        cur_run  = 0;
        low_run  = 0;
        done_cnt = 0;
    endtask

    task automatic push(input logic [DATABIT-1:0] d, input logic v);
        @(negedge clk);
        s_valid_i = v;
        s_data_i  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_valid_i = 1'b0;
        end
    endtask

    task automatic wait_mvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            s_valid_i = 1'b0;
            if (m_valid_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; s_valid_i = 1'b0; s_data_i = '0; m_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++; if (s_ready_o !== 1'b0) $display("FAIL reset_s_ready: got %b expected 0", s_ready_o); else pass_cnt++;
        total_cnt++; if (m_valid_o !== 1'b0) $display("FAIL reset_m_valid: got %b expected 0", m_valid_o); else pass_cnt++;
        total_cnt++; if (m_data_o !== 32'h0) $display("FAIL reset_m_data: got %h expected 0", m_data_o); else pass_cnt++;
        total_cnt++; if (burst_done_o !== 1'b0) $display("FAIL reset_done: got %b expected 0", burst_done_o); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++; if (s_ready_o !== 1'b1) $display("FAIL reset_release_s_ready: got %b expected 1", s_ready_o); else pass_cnt++;
        clear_mon();
    endtask

    task automatic test_basic();
        int bad;
        m_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) push(32'hA0 + i, 1'b1);
        idle(20);
        total_cnt++; if (words.size() != 4) $display("FAIL basic_count: got %0d expected 4", words.size()); else pass_cnt++;
        bad = 0;
        for (int i = 0; i < words.size() && i < 4; i++) if (words[i] !== 32'hA0 + i) bad++;
        total_cnt++; if (bad != 0 || words.size() != 4) $display("FAIL basic_data: got %0d wrong words expected 0", bad); else pass_cnt++;
        total_cnt++; if (runs.size() != 1 || runs[0] != 4) $display("FAIL basic_run: got %0d runs expected one run of 4", runs.size()); else pass_cnt++;
        total_cnt++; if (done_cnt != 1) $display("FAIL basic_done: got %0d pulses expected 1", done_cnt); else pass_cnt++;
        clear_mon();
    endtask

    task automatic test_permission_wait();
        int bad;
        m_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h11 + i, 1'b1);
        @(negedge clk);
        s_valid_i = 1'b0;
        total_cnt++; if (s_ready_o !== 1'b0) $display("FAIL wait_entry_s_ready: got %b expected 0", s_ready_o); else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (s_ready_o !== 1'b0 || m_valid_o !== 1'b0) bad++;
        end
        total_cnt++; if (bad != 0) $display("FAIL wait_hold: got %0d active cycles expected 0", bad); else pass_cnt++;
        m_ready_i = 1'b1;
        @(negedge clk);
        total_cnt++; if (m_valid_o !== 1'b1 || m_data_o !== 32'h11) $display("FAIL wait_first_word: got v=%b d=%h expected v=1 d=11", m_valid_o, m_data_o); else pass_cnt++;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            total_cnt++; if (m_valid_o !== 1'b1 || m_data_o !== 32'h11 + k) $display("FAIL wait_word%0d: got v=%b d=%h expected v=1 d=%h", k, m_valid_o, m_data_o, 32'h11 + k); else pass_cnt++;
            total_cnt++; if (s_ready_o !== 1'b0) $display("FAIL wait_send_s_ready%0d: got %b expected 0", k, s_ready_o); else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++; if (m_valid_o !== 1'b0 || burst_done_o !== 1'b1 || s_ready_o !== 1'b0 || m_data_o !== 32'h0) $display("FAIL wait_end: got v=%b done=%b rdy=%b d=%h expected v=0 done=1 rdy=0 d=0", m_valid_o, burst_done_o, s_ready_o, m_data_o); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (burst_done_o !== 1'b0 || s_ready_o !== 1'b0) $display("FAIL wait_gap2: got done=%b rdy=%b expected done=0 rdy=0", burst_done_o, s_ready_o); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (s_ready_o !== 1'b1) $display("FAIL wait_refill: got %b expected 1", s_ready_o); else pass_cnt++;
        idle(5);
        clear_mon();
    endtask

    task automatic test_bubbly();
        int bad;
        m_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(32'hB0 + i, 1'b1);
            push(32'hDEAD_0000 + i, 1'b0);
        end
        idle(20);
        bad = 0;
        for (int i = 0; i < words.size() && i < 4; i++) if (words[i] !== 32'hB0 + i) bad++;
        total_cnt++; if (words.size() != 4 || bad != 0) $display("FAIL bubbly_data: got %0d words %0d wrong expected 4 words 0 wrong", words.size(), bad); else pass_cnt++;
        total_cnt++; if (runs.size() != 1 || runs[0] != 4) $display("FAIL bubbly_run: got %0d runs expected one run of 4", runs.size()); else pass_cnt++;
        clear_mon();
    endtask

    task automatic test_mready_drop();
        int bad;
        bit ok;
        m_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) push(32'hC0 + i, 1'b1);
        wait_mvalid(ok);
        total_cnt++; if (!ok) $display("FAIL drop_start: got no m_valid expected burst start"); else pass_cnt++;
        @(negedge clk);
        m_ready_i = 1'b0;
        idle(20);
        bad = 0;
        for (int i = 0; i < words.size() && i < 4; i++) if (words[i] !== 32'hC0 + i) bad++;
        total_cnt++; if (words.size() != 4 || bad != 0) $display("FAIL drop_data: got %0d words %0d wrong expected 4 words 0 wrong", words.size(), bad); else pass_cnt++;
        total_cnt++; if (runs.size() != 1 || runs[0] != 4) $display("FAIL drop_run: got %0d runs expected one run of 4", runs.size()); else pass_cnt++;
        total_cnt++; if (done_cnt != 1) $display("FAIL drop_done: got %0d pulses expected 1", done_cnt); else pass_cnt++;
        m_ready_i = 1'b1;
        clear_mon();
    endtask

    task automatic test_back_to_back();
        int  k;
        bit  acc;
        int  bad;
        k = 0; acc = 1'b0;
        m_ready_i = 1'b1;
        for (int cyc = 0; cyc < 300 && k < 12; cyc++) begin
            @(negedge clk);
            if (acc) k++;
            if (k < 12) begin
                s_valid_i = 1'b1;
                s_data_i  = 32'hD0 + k;
            end else begin
                s_valid_i = 1'b0;
            end
            #1 acc = s_valid_i && s_ready_o;
        end
        total_cnt++; if (k != 12) $display("FAIL b2b_accepts: got %0d expected 12", k); else pass_cnt++;
        idle(25);
        bad = 0;
        for (int i = 0; i < words.size() && i < 12; i++) if (words[i] !== 32'hD0 + i) bad++;
        total_cnt++; if (words.size() != 12 || bad != 0) $display("FAIL b2b_data: got %0d words %0d wrong expected 12 words 0 wrong", words.size(), bad); else pass_cnt++;
        total_cnt++; if (runs.size() != 3 || runs[0] != 4 || runs[1] != 4 || runs[2] != 4) $display("FAIL b2b_runs: got %0d runs expected three runs of 4", runs.size()); else pass_cnt++;
        total_cnt++; if (lows.size() != 3 || lows[1] != 7 || lows[2] != 7) $display("FAIL b2b_gap: got %0d bursts gaps %0d,%0d expected 3 bursts gaps 7,7", lows.size(), (lows.size() > 1) ? lows[1] : -1, (lows.size() > 2) ? lows[2] : -1); else pass_cnt++;
        total_cnt++; if (done_cnt != 3) $display("FAIL b2b_done: got %0d pulses expected 3", done_cnt); else pass_cnt++;
        clear_mon();
    endtask

    task automatic test_reset_mid_send();
        int bad;
        bit ok;
        m_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) push(32'hE0 + i, 1'b1);
        wait_mvalid(ok);
        total_cnt++; if (!ok) $display("FAIL rstsend_start: got no m_valid expected burst start"); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        total_cnt++; if (m_valid_o !== 1'b1 || m_data_o !== 32'hE2) $display("FAIL rstsend_word3: got v=%b d=%h expected v=1 d=e2", m_valid_o, m_data_o); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (m_valid_o !== 1'b0 || m_data_o !== 32'h0 || s_ready_o !== 1'b0 || burst_done_o !== 1'b0) $display("FAIL rstsend_cleared: got v=%b d=%h rdy=%b done=%b expected all 0", m_valid_o, m_data_o, s_ready_o, burst_done_o); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total_cnt++; if (s_ready_o !== 1'b1) $display("FAIL rstsend_release: got %b expected 1", s_ready_o); else pass_cnt++;
        clear_mon();
        for (int i = 0; i < 4; i++) push(32'hF0 + i, 1'b1);
        idle(20);
        bad = 0;
        for (int i = 0; i < words.size() && i < 4; i++) if (words[i] !== 32'hF0 + i) bad++;
        total_cnt++; if (words.size() != 4 || bad != 0) $display("FAIL rstsend_fresh_data: got %0d words %0d wrong expected 4 words 0 wrong", words.size(), bad); else pass_cnt++;
        total_cnt++; if (done_cnt != 1 || runs.size() != 1 || runs[0] != 4) $display("FAIL rstsend_fresh_run: got %0d pulses %0d runs expected 1 pulse one run of 4", done_cnt, runs.size()); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_permission_wait();
        test_bubbly();
        test_mready_drop();
        test_back_to_back();
        test_reset_mid_send();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
